dmem_arbiter: RTL

Round-robin arbiter sharing one data memory (single-port, combinational read, synchronous write) between NCORES X-RISC cores in the multi-core build. It sits between each core's load/store port and the shared data memory. It serializes accesses with a req/gnt handshake and returns read data through a registered response, sustaining one access per cycle under contention.

---
 rtl/xrisc_pkg.sv | 9 +
 rtl/dmem_arbiter_if.sv | 12 +
 rtl/dmem_arbiter_rr_pick.sv | 23 ++
 rtl/dmem_arbiter.sv | 62 ++++++
 4 files changed

// File: rtl/xrisc_pkg.sv
// xrisc_pkg: shared X-RISC widths, arbiter state type and modulo-N pointer increment
package xrisc_pkg;
  localparam int XLEN = 32;
  localparam int NCORES = 2;
  typedef enum logic {IDLE, ACCESS} arb_state_t;
  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 == n) ? 0 : i + 1;
  endfunction
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: core req/we/addr/wdata -> gnt/rvalid/rdata plus memory mem_we/mem_addr/mem_wdata <- mem_rdata; slave = arbiter, master = cores and memory
interface dmem_arbiter_if #(
  parameter int NCORES = xrisc_pkg::NCORES,
  parameter int XLEN = xrisc_pkg::XLEN
);
  logic [NCORES-1:0] req, we, gnt, rvalid;
  logic [NCORES*XLEN-1:0] addr, wdata;
  logic [XLEN-1:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic mem_we;
  modport slave(input req, we, addr, wdata, mem_rdata, output gnt, rvalid, rdata, mem_we, mem_addr, mem_wdata);
  modport master(output req, we, addr, wdata, mem_rdata, input gnt, rvalid, rdata, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/dmem_arbiter_rr_pick.sv
// rr_pick: cand_i/ptr_i in, gnt_o (one-hot), idx_o, valid_o out; first candidate at or after ptr_i, wrapping modulo N
module rr_pick #(
  parameter int N = 2,
  localparam int PW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  cand_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);
  int j;
  always_comb begin
    j = 0;
    idx_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % N;
      idx_o = |(cand_i & (N'(1) << j)) ? PW'(j) : idx_o;
    end
    valid_o = |cand_i;
    gnt_o = valid_o ? N'(1) << idx_o : '0;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of one data memory by NCORES cores; clk, reset (async, active-high), bus (slave view: core handshake + memory port)
module dmem_arbiter #(
  parameter int NCORES = xrisc_pkg::NCORES,
  parameter int XLEN = xrisc_pkg::XLEN
) (
  input logic clk,
  input logic reset,
  dmem_arbiter_if.slave bus
);
  import xrisc_pkg::*;
  localparam int PW = NCORES > 1 ? $clog2(NCORES) : 1;
  arb_state_t state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, win_q, pick_idx;
  logic [NCORES-1:0] win_oh_q, mask, cand, pick_oh, rvalid_q;
  logic we_q, pick_v, ld_done;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
  rr_pick #(.N(NCORES)) u_pick (
    .cand_i(cand),
    .ptr_i(ptr_d),
    .gnt_o(pick_oh),
    .idx_o(pick_idx),
    .valid_o(pick_v)
  );
  // During ACCESS the pointer has already moved past the current winner, so a back-to-back pick starts there.
  always_comb begin
    mask = state_q == ACCESS ? win_oh_q : '0;
    cand = bus.req & ~mask;
    ptr_d = state_q == ACCESS ? PW'(wrap_inc(int'(win_q), NCORES)) : ptr_q;
    state_d = pick_v ? ACCESS : IDLE;
    ld_done = state_q == ACCESS && !we_q;
    bus.gnt = mask;
    bus.mem_we = state_q == ACCESS && we_q;
    bus.mem_addr = addr_q;
    bus.mem_wdata = wdata_q;
    bus.rvalid = rvalid_q;
    bus.rdata = rdata_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      win_q <= '0;
      win_oh_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rvalid_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      rvalid_q <= ld_done ? win_oh_q : '0;
      if (ld_done) rdata_q <= bus.mem_rdata;
      if (pick_v) begin
        win_q <= pick_idx;
        win_oh_q <= pick_oh;
        we_q <= bus.we[pick_idx];
        addr_q <= bus.addr[pick_idx*XLEN +: XLEN];
        wdata_q <= bus.wdata[pick_idx*XLEN +: XLEN];
      end
    end
endmodule
